// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request record for the register-file write path.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. prio names the requester that wins a tie.
module rr_arbiter2 #(
  parameter int PRIO_INIT = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic prio;

  // Grant the lone requester, or the favoured one when both ask.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Every grant is a completed transfer; favour the other side next time.
  always_ff @(posedge Clock) begin
    if (!Reset)      prio <= PRIO_INIT[0];
    else if (|gnt)   prio <= gnt[0];
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback and
// tracks pending writes per register for RAW stalls at issue.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int PRIO_INIT = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Req0Valid,
  output logic                Req0Ready,
  input  logic [ADDR_W-1:0]   Req0Addr,
  input  logic [DATA_W-1:0]   Req0Data,
  input  logic                Req1Valid,
  output logic                Req1Ready,
  input  logic [ADDR_W-1:0]   Req1Addr,
  input  logic [DATA_W-1:0]   Req1Data,
  input  logic                ReserveValid,
  input  logic [ADDR_W-1:0]   ReserveAddr,
  output logic                ReserveStall,
  output logic [NUM_REGS-1:0] Busy,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteAddr,
  output logic [DATA_W-1:0]   WriteData
);
  wb_req_t             req0, req1, win;
  logic [1:0]          gnt;
  logic                accept;
  logic [NUM_REGS-1:0] retire, busy_live, claim, busy_nxt;

  assign req0 = '{valid: Req0Valid, addr: Req0Addr, data: Req0Data};
  assign req1 = '{valid: Req1Valid, addr: Req1Addr, data: Req1Data};

  // Grants are suppressed while Reset is low so nothing is accepted then.
  rr_arbiter2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
    .Clock (Clock),
    .Reset (Reset),
    .req   ({req1.valid, req0.valid}),
    .en    (Reset),
    .gnt   (gnt)
  );

  assign Req0Ready = gnt[0];
  assign Req1Ready = gnt[1];
  assign accept    = |gnt;
  assign win       = gnt[1] ? req1 : req0;

  // Output stage: one registered write per accepted request; r0 is never written.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else if (accept) begin
      RegWrite  <= (win.addr != REG_ZERO);
      WriteAddr <= win.addr;
      WriteData <= win.data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // Scoreboard next state: a write retiring now frees its register for a
  // same-cycle reservation, and the new reservation wins over the clear.
  always_comb begin
    retire = '0;
    if (RegWrite) retire[WriteAddr] = 1'b1;
    busy_live    = Busy & ~retire;
    ReserveStall = Reset & ReserveValid & busy_live[ReserveAddr];
    claim = '0;
    if (Reset && ReserveValid && (ReserveAddr != REG_ZERO) && !busy_live[ReserveAddr])
      claim[ReserveAddr] = 1'b1;
    busy_nxt    = busy_live | claim;
    busy_nxt[0] = 1'b0;
  end

  // Pending-write bitmap register.
  always_ff @(posedge Clock) begin
    if (!Reset) Busy <= '0;
    else        Busy <= busy_nxt;
  end
endmodule
